fetch_rv: RTL and testbench

- Instruction fetch stage directly upstream of bram_rv's read port.
- Holds a byte-address PC and issues word reads to bram_rv over its rd_ready/rd_valid handshake.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a one-cycle redirect (branch/jump) that flushes buffered and in-flight instructions.

---
 rtl/fetch_rv.sv | 153 +++++++++++++++
 tb/tb_fetch_rv.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_rv.sv
// Instruction fetch stage: byte PC, one outstanding bram read, prefetch FIFO toward decode.
// Optional build macro FETCH_STALL_CNT_EN adds o_stall_cnt (decode backpressure cycle counter).
module fetch_rv #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH+1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd_ready,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_rd_valid,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH+1:0] i_redirect_addr,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH+1:0] o_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           o_stall_cnt
`endif
);

    localparam int PW    = ADDR_WIDTH + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      pc, pc_nxt;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full;
    logic               rd_req;
    logic               push, pop;

    logic [DEPTH-1:0][PW-1:0]         fifo_pc;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] fifo_instr;

    // Low two redirect bits are forced to zero; they are intentionally unused.
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^i_redirect_addr[1:0];

    assign full          = (count == CNT_W'(DEPTH));
    assign o_instr_valid = (count != '0);
    assign pop           = o_instr_valid && i_instr_ready && !i_redirect_valid;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_REQ;
            pc    <= {RESET_PC[PW-1:2], 2'b00};
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        rd_req    = 1'b0;
        push      = 1'b0;
        unique case (state)
            S_REQ: begin
                rd_req = !full && !i_redirect_valid;
                if (rd_req) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_rd_valid) begin
                    state_nxt = S_REQ;
                    if (!i_redirect_valid) begin
                        push   = 1'b1;
                        pc_nxt = pc + PW'(4);
                    end
                end else if (i_redirect_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                // Response belongs to the pre-redirect stream: swallow it.
                if (i_mem_rd_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
        if (i_redirect_valid) pc_nxt = {i_redirect_addr[PW-1:2], 2'b00};
    end

    // Reset is async; gate the request so bram never sees it while held in reset.
    assign o_mem_rd_ready = rd_req && i_rst_n;
    assign o_mem_addr     = pc[PW-1:2];

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= i_mem_data;
        end
    end

    assign o_instr = fifo_instr[rd_ptr];
    assign o_pc    = fifo_pc[rd_ptr];

`ifdef FETCH_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Decode backpressure counter, saturating; survives redirects
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (o_instr_valid && !i_instr_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_rv.sv
// Self-checking bench for fetch_rv with a small bram_rv response model (programmable latency).
module tb_fetch_rv;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int PW = AW + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd_ready;
    logic [DW-1:0]  mem_data = '0;
    logic           mem_rd_valid = 1'b0;
    logic           redir = 1'b0;
    logic [PW-1:0]  redir_addr = '0;
    logic [DW-1:0]  instr;
    logic [PW-1:0]  pc;
    logic           ivalid;
    logic           iready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]    stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_rv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(12'h000), .DEPTH(4)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_mem_addr       (mem_addr),
        .o_mem_rd_ready   (mem_rd_ready),
        .i_mem_data       (mem_data),
        .i_mem_rd_valid   (mem_rd_valid),
        .i_redirect_valid (redir),
        .i_redirect_addr  (redir_addr),
        .o_instr          (instr),
        .o_pc             (pc),
        .o_instr_valid    (ivalid),
        .i_instr_ready    (iready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .o_stall_cnt      (stall_cnt)
`endif
    );

    // bram_rv model: response bram_lat cycles after an accepted request.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            bram_lat = 1;
    int            pend_cnt = 0;
    logic [AW-1:0] pend_addr = '0;

    always @(posedge clk) begin
        mem_rd_valid <= 1'b0;
        if (!rst_n) begin
            pend_cnt <= 0;
        end else if (pend_cnt != 0) begin
            if (pend_cnt == 1) begin
                mem_rd_valid <= 1'b1;
                mem_data     <= mem[pend_addr];
            end
            pend_cnt <= pend_cnt - 1;
        end else if (mem_rd_ready) begin
            if (bram_lat <= 1) begin
                mem_rd_valid <= 1'b1;
                mem_data     <= mem[mem_addr];
            end else begin
                pend_cnt  <= bram_lat - 1;
                pend_addr <= mem_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Returns at the negedge of the first post-reset cycle (C0) with rst_n released.
    task automatic do_reset(input int lat);
        @(negedge clk);
        rst_n    = 1'b0;
        redir    = 1'b0;
        iready   = 1'b0;
        bram_lat = lat;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", ivalid, 0);
        chk("rst_rd_ready", mem_rd_ready, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; samples that cycle first, records every accepted instruction.
    logic [PW-1:0] q_pc[$];
    logic [DW-1:0] q_ins[$];

    task automatic collect(input int n, input int maxc);
        int c = 0;
        q_pc.delete();
        q_ins.delete();
        while (1) begin
            #1;
            if (ivalid && iready) begin
                q_pc.push_back(pc);
                q_ins.push_back(instr);
            end
            c++;
            if (q_pc.size() >= n || c >= maxc) break;
            @(negedge clk);
        end
        total++;
        if (q_pc.size() < n) begin
            bad++;
            $display("FAIL collect_timeout: got %0d entries expected %0d", q_pc.size(), n);
        end
    endtask

    task automatic chk_entry(input string name, input int i, input logic [PW-1:0] epc,
                             input logic [DW-1:0] eins);
        if (i < q_pc.size()) begin
            chk({name, "_pc"}, q_pc[i], epc);
            chk({name, "_instr"}, q_ins[i], eins);
        end else begin
            total++;
            bad++;
            $display("FAIL %s: entry %0d missing, expected pc %0h", name, i, epc);
        end
    endtask

    // Called at a negedge; leaves the bench at #1 into the matching cycle.
    task automatic wait_req(input logic [AW-1:0] a, input int maxc);
        int c = 0;
        while (1) begin
            #1;
            c++;
            if (mem_rd_ready && mem_addr == a) break;
            if (c >= maxc) begin
                total++;
                bad++;
                $display("FAIL wait_req_timeout: no request for word %0h", a);
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic          rdy;
        logic          exp_v;
        logic [PW-1:0] exp_pc;
        logic [DW-1:0] exp_ins;
        logic          exp_rr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tab[10];
    int   exp_stall;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        // Streaming with decode always ready: one instruction every 2 cycles.
        tab[0] = '{1'b1, 1'b0, 12'h000, 32'h00, 1'b1, 10'd0};
        tab[1] = '{1'b1, 1'b0, 12'h000, 32'h00, 1'b0, 10'd0};
        tab[2] = '{1'b1, 1'b1, 12'h000, 32'h11, 1'b1, 10'd1};
        tab[3] = '{1'b1, 1'b0, 12'h000, 32'h00, 1'b0, 10'd1};
        tab[4] = '{1'b1, 1'b1, 12'h004, 32'h22, 1'b1, 10'd2};
        tab[5] = '{1'b1, 1'b0, 12'h000, 32'h00, 1'b0, 10'd2};
        tab[6] = '{1'b1, 1'b1, 12'h008, 32'h33, 1'b1, 10'd3};
        tab[7] = '{1'b1, 1'b0, 12'h000, 32'h00, 1'b0, 10'd3};
        tab[8] = '{1'b1, 1'b1, 12'h00C, 32'h44, 1'b1, 10'd4};
        tab[9] = '{1'b1, 1'b0, 12'h000, 32'h00, 1'b0, 10'd4};

        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            iready = tab[k].rdy;
            #1;
            chk($sformatf("t%0d_valid", k), ivalid, tab[k].exp_v);
            chk($sformatf("t%0d_rd_ready", k), mem_rd_ready, tab[k].exp_rr);
            chk($sformatf("t%0d_addr", k), mem_addr, tab[k].exp_addr);
            if (tab[k].exp_v) begin
                chk($sformatf("t%0d_pc", k), pc, tab[k].exp_pc);
                chk($sformatf("t%0d_instr", k), instr, tab[k].exp_ins);
            end
            @(negedge clk);
        end

        // Decode stall for 20 cycles: FIFO fills to 4, head holds, then drains in order.
        do_reset(1);
        exp_stall = 0;
        for (int k = 0; k < 20; k++) begin
            iready = 1'b0;
            #1;
            chk($sformatf("stall%0d_valid", k), ivalid, (k >= 2));
            if (k >= 2) begin
                chk($sformatf("stall%0d_pc", k), pc, 0);
                chk($sformatf("stall%0d_instr", k), instr, 32'h11);
                exp_stall++;
            end
            if (k >= 8) chk($sformatf("stall%0d_rd_ready", k), mem_rd_ready, 0);
            @(negedge clk);
        end
        iready = 1'b1;
        collect(6, 40);
        chk_entry("drain0", 0, 12'h000, 32'h11);
        chk_entry("drain1", 1, 12'h004, 32'h22);
        chk_entry("drain2", 2, 12'h008, 32'h33);
        chk_entry("drain3", 3, 12'h00C, 32'h44);
        chk_entry("drain4", 4, 12'h010, 32'hA000_0004);
        chk_entry("drain5", 5, 12'h014, 32'hA000_0005);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, exp_stall);
`endif

        // Redirect while WAIT for pc 0x8 with response still pending (DROP path).
        do_reset(2);
        iready = 1'b1;
        wait_req(10'd2, 30);
        @(negedge clk);
        redir = 1'b1; redir_addr = 12'h102;
        #1;
        chk("drop_rd_ready", mem_rd_ready, 0);
        @(negedge clk);
        redir = 1'b0;
        #1;
        chk("drop_valid_after", ivalid, 0);
        @(negedge clk);
        collect(2, 30);
        chk_entry("drop0", 0, 12'h100, 32'hA000_0040);
        chk_entry("drop1", 1, 12'h104, 32'hA000_0041);

        // Redirect in WAIT on the same cycle as the response (discard, straight to REQ).
        do_reset(1);
        iready = 1'b1;
        wait_req(10'd2, 30);
        @(negedge clk);
        redir = 1'b1; redir_addr = 12'h200;
        #1;
        chk("wrsp_rd_ready", mem_rd_ready, 0);
        @(negedge clk);
        redir = 1'b0;
        #1;
        chk("wrsp_valid_after", ivalid, 0);
        chk("wrsp_rd_ready_after", mem_rd_ready, 1);
        chk("wrsp_addr_after", mem_addr, 10'h080);
        @(negedge clk);
        collect(1, 20);
        chk_entry("wrsp0", 0, 12'h200, 32'hA000_0080);

        // Redirect coinciding with a pop while 3 entries are buffered.
        do_reset(1);
        iready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("pop3_valid_pre", ivalid, 1);
        chk("pop3_pc_pre", pc, 0);
        chk("pop3_rd_ready_pre", mem_rd_ready, 1);
        iready = 1'b1; redir = 1'b1; redir_addr = 12'h080;
        #1;
        chk("pop3_rd_ready_redir", mem_rd_ready, 0);
        @(negedge clk);
        redir = 1'b0;
        #1;
        chk("pop3_valid_after", ivalid, 0);
        chk("pop3_addr_after", mem_addr, 10'h020);
        chk("pop3_rd_ready_after", mem_rd_ready, 1);
        @(negedge clk);
        collect(1, 20);
        chk_entry("pop3_0", 0, 12'h080, 32'hA000_0020);

        // Redirect to the last word: PC wraps to 0 after it; 3-cycle redirect latency from REQ.
        do_reset(1);
        iready = 1'b1; redir = 1'b1; redir_addr = 12'hFFC;
        #1;
        chk("wrap_rd_ready_redir", mem_rd_ready, 0);
        @(negedge clk);
        redir = 1'b0;
        #1;
        chk("wrap_c1_valid", ivalid, 0);
        chk("wrap_c1_rd_ready", mem_rd_ready, 1);
        chk("wrap_c1_addr", mem_addr, 10'h3FF);
        @(negedge clk);
        #1;
        chk("wrap_c2_valid", ivalid, 0);
        @(negedge clk);
        #1;
        chk("wrap_c3_valid", ivalid, 1);
        chk("wrap_c3_pc", pc, 12'hFFC);
        chk("wrap_c3_instr", instr, 32'hA000_03FF);
        @(negedge clk);
        collect(1, 20);
        chk_entry("wrap_next", 0, 12'h000, 32'h11);

        // Asynchronous reset asserted mid-WAIT with an entry buffered.
        do_reset(1);
        iready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("arst_valid_pre", ivalid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ivalid, 0);
        chk("arst_rd_ready", mem_rd_ready, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("arst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        iready = 1'b1;
        collect(2, 20);
        chk_entry("arst0", 0, 12'h000, 32'h11);
        chk_entry("arst1", 1, 12'h004, 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
